// File: rtl/tdc_meas_sequencer.sv
// ---------------------------------------------------------------------------
// tdc_meas_sequencer
//
// Purpose:
//   Drives the time-to-digital counter through bursts of 2**AVG_LOG2
//   conversions. Each conversion is a clear pulse, then a start pulse, then
//   a wait for the counter's done level to rise. The captured counts are
//   summed and the sum is handed to the host over a valid/ready handshake.
//   This block is the counter's only driver.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   req          in   start a burst (looked at in IDLE only)
//   abort        in   cancel the burst in CLEAR/START/WAIT_DONE
//   busy         out  high whenever the sequencer is not idle
//   cnt_clear    out  one-cycle clear pulse to the counter
//   cnt_start    out  one-cycle start pulse to the counter
//   cnt_running  in   counter converting (status only)
//   cnt_ready    in   counter conversion done (level)
//   cnt_value    in   counter result, valid while cnt_ready is high
//   res_data     out  sum of the burst samples (CNT_W+AVG_LOG2 bits)
//   res_valid    out  res_data valid, held until res_ready
//   res_ready    in   host accepts the result
//   res_timeout  out  at least one sample of this burst timed out
//
// Build option:
//   TDC_SEQ_TIMEOUT_EN  when defined, a sample that does not arrive within
//                       TIMEOUT_CYC cycles of WAIT_DONE is forced to all-ones
//                       and accepted, and res_timeout is raised. When not
//                       defined, WAIT_DONE waits until abort or rst and
//                       res_timeout stays 0.
//
// States:
//   state       | meaning
//   S_IDLE      | waiting for req
//   S_CLEAR     | cnt_clear pulse
//   S_START     | cnt_start pulse
//   S_WAIT_DONE | waiting for a rising edge on cnt_ready
//   S_OUTPUT    | res_valid held until res_ready
// ---------------------------------------------------------------------------
module tdc_meas_sequencer #(
    parameter int CNT_W       = 8,
    parameter int AVG_LOG2    = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req,
    input  logic                      abort,
    output logic                      busy,
    output logic                      cnt_clear,
    output logic                      cnt_start,
    input  logic                      cnt_running,
    input  logic                      cnt_ready,
    input  logic [CNT_W-1:0]          cnt_value,
    output logic [CNT_W+AVG_LOG2-1:0] res_data,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic                      res_timeout
);

    localparam int ACC_W = CNT_W + AVG_LOG2;
    localparam int IDX_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'((1 << AVG_LOG2) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_START,
        S_WAIT_DONE,
        S_OUTPUT
    } state_t;

    state_t           state;
    logic             ready_q;
    logic [ACC_W-1:0] acc;
    logic [IDX_W-1:0] sample_idx;
    logic             rise;
    logic             tmo;
    logic             take;
    logic [CNT_W-1:0] sample;

    // Sequencing only needs the done level; the running status is carried on
    // the port for the readout side and is deliberately not consumed here.
    logic unused_running;
    assign unused_running = cnt_running;

`ifdef TDC_SEQ_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);

    // Down-counter loaded on entry to WAIT_DONE; terminal count on the last
    // allowed waiting cycle forces the sample.
    logic [TMO_W-1:0] wait_cnt;
    assign tmo = (state == S_WAIT_DONE) && !rise && (wait_cnt == '0);
`else
    assign tmo = 1'b0;
`endif

    // Only a fresh rising edge counts, so a done level left high from an
    // earlier conversion can never be taken as a new sample.
    assign rise     = cnt_ready & ~ready_q;
    assign take     = rise | tmo;
    assign sample   = rise ? cnt_value : {CNT_W{1'b1}};
    assign res_data = acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            ready_q     <= 1'b0;
            acc         <= '0;
            sample_idx  <= '0;
            busy        <= 1'b0;
            cnt_clear   <= 1'b0;
            cnt_start   <= 1'b0;
            res_valid   <= 1'b0;
            res_timeout <= 1'b0;
`ifdef TDC_SEQ_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
        end else begin
            ready_q   <= cnt_ready;
            cnt_clear <= 1'b0;
            cnt_start <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (req) begin
                        state       <= S_CLEAR;
                        acc         <= '0;
                        sample_idx  <= '0;
                        res_timeout <= 1'b0;
                        busy        <= 1'b1;
                        cnt_clear   <= 1'b1;
                    end
                end

                S_CLEAR: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        acc   <= '0;
                    end else begin
                        state     <= S_START;
                        cnt_start <= 1'b1;
                    end
                end

                S_START: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        acc   <= '0;
                    end else begin
                        state <= S_WAIT_DONE;
`ifdef TDC_SEQ_TIMEOUT_EN
                        wait_cnt <= TMO_LOAD;
`endif
                    end
                end

                S_WAIT_DONE: begin
                    // abort wins over a sample arriving in the same cycle
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        acc   <= '0;
                    end else if (take) begin
                        acc <= acc + ACC_W'(sample);
                        if (tmo) begin
                            res_timeout <= 1'b1;
                        end
                        if (sample_idx == LAST_IDX) begin
                            state     <= S_OUTPUT;
                            res_valid <= 1'b1;
                        end else begin
                            sample_idx <= sample_idx + IDX_W'(1);
                            state      <= S_CLEAR;
                            cnt_clear  <= 1'b1;
                        end
                    end else begin
`ifdef TDC_SEQ_TIMEOUT_EN
                        wait_cnt <= wait_cnt - TMO_W'(1);
`endif
                    end
                end

                S_OUTPUT: begin
                    if (res_ready) begin
                        state     <= S_IDLE;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_meas_sequencer.sv
// ---------------------------------------------------------------------------
// tb_tdc_meas_sequencer
//
// Self-checking bench for tdc_meas_sequencer (CNT_W=8, AVG_LOG2=2,
// TIMEOUT_CYC=16). A stand-in TDC counter answers each start pulse after a
// random delay with a value from a plan queue (or a random value); an entry
// of -1 makes the counter never finish. A burst-level reference model is
// advanced once per clock from the same inputs the design sees, and every
// cycle the design outputs are compared against it. Directed scenarios add
// literal expectations on top. Honours TDC_SEQ_TIMEOUT_EN like the design.
// ---------------------------------------------------------------------------
module tb_tdc_meas_sequencer;

    localparam int CNT_W    = 8;
    localparam int AVG_LOG2 = 2;
    localparam int TMO      = 16;
    localparam int NSAMP    = 1 << AVG_LOG2;
`ifdef TDC_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic                      clk;
    logic                      rst;
    logic                      req;
    logic                      abort;
    logic                      busy;
    logic                      cnt_clear;
    logic                      cnt_start;
    logic                      cnt_running;
    logic                      cnt_ready;
    logic [CNT_W-1:0]          cnt_value;
    logic [CNT_W+AVG_LOG2-1:0] res_data;
    logic                      res_valid;
    logic                      res_ready;
    logic                      res_timeout;

    tdc_meas_sequencer #(
        .CNT_W      (CNT_W),
        .AVG_LOG2   (AVG_LOG2),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .abort      (abort),
        .busy       (busy),
        .cnt_clear  (cnt_clear),
        .cnt_start  (cnt_start),
        .cnt_running(cnt_running),
        .cnt_ready  (cnt_ready),
        .cnt_value  (cnt_value),
        .res_data   (res_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_timeout(res_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tot  = 0;
    int n_pass = 0;

    // reference model: where in the burst we are, running sum, samples taken
    int ph;       // 0 idle, 1 clear, 2 start, 3 waiting, 4 presenting
    int m_sum;
    int m_n;
    int m_w;
    bit m_to;
    bit m_prev;

    // stand-in counter
    int plan[$];
    int cd;
    int pend;
    int n_clr, n_start, n_rise, n_valid;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    // one clock edge worth of burst rules, using the inputs at that edge
    task automatic model_step();
        bit rise;
        bit got;
        int v;
        rise   = cnt_ready && !m_prev;
        m_prev = cnt_ready;
        if (rst) begin
            ph = 0; m_sum = 0; m_n = 0; m_w = 0; m_to = 0; m_prev = 0;
            return;
        end
        got = 0;
        v   = 0;
        case (ph)
            0: if (req) begin ph = 1; m_sum = 0; m_n = 0; m_to = 0; end
            1: ph = abort ? 0 : 2;
            2: begin ph = abort ? 0 : 3; m_w = 0; end
            3: begin
                if (abort) ph = 0;
                else begin
                    m_w++;
                    if (rise) begin got = 1; v = int'(cnt_value); end
                    else if (TO_EN && m_w >= TMO) begin got = 1; v = (1 << CNT_W) - 1; m_to = 1; end
                    if (got) begin
                        m_sum += v;
                        m_n++;
                        ph = (m_n == NSAMP) ? 4 : 1;
                    end
                end
            end
            4: if (res_ready) ph = 0;
            default: ph = 0;
        endcase
    endtask

    task automatic compare();
        chk("busy",        busy,        (ph != 0));
        chk("cnt_clear",   cnt_clear,   (ph == 1));
        chk("cnt_start",   cnt_start,   (ph == 2));
        chk("res_valid",   res_valid,   (ph == 4));
        chk("res_timeout", res_timeout, m_to);
        if (ph == 4) chk("res_data", res_data, m_sum);
    endtask

    task automatic respond();
        int v;
        n_clr   += int'(cnt_clear);
        n_start += int'(cnt_start);
        n_valid += int'(res_valid);
        if (cnt_clear) begin
            cnt_ready = 0; cnt_running = 0; cd = 0;
        end
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                cnt_ready   = 1;
                cnt_running = 0;
                cnt_value   = CNT_W'(pend);
                n_rise++;
            end
        end
        if (cnt_start) begin
            cnt_running = 1;
            v = (plan.size() > 0) ? plan.pop_front() : int'($urandom_range(0, 255));
            if (v >= 0) begin
                pend = v;
                cd   = int'($urandom_range(1, 3));
            end else begin
                cd = 0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        compare();
        respond();
    endtask

    task automatic pulse_req();
        req = 1; tick(); req = 0;
    endtask

    task automatic wait_valid(input int budget, input string nm);
        int k = 0;
        while (!res_valid && k < budget) begin tick(); k++; end
        chk(nm, res_valid, 1);
    endtask

    task automatic wait_rises(input int target, input int budget, input string nm);
        int k = 0;
        while (n_rise < target && k < budget) begin tick(); k++; end
        chk(nm, (n_rise >= target), 1);
    endtask

    initial begin
        int c0;
        int hb;
        rst = 1; req = 0; abort = 0; res_ready = 0;
        cnt_ready = 0; cnt_running = 0; cnt_value = '0;
        ph = 0; m_sum = 0; m_n = 0; m_w = 0; m_to = 0; m_prev = 0;
        cd = 0; pend = 0; n_clr = 0; n_start = 0; n_rise = 0; n_valid = 0;

        repeat (3) tick();
        chk("reset_outputs", {busy, cnt_clear, cnt_start, res_valid, res_timeout, res_data}, 0);
        rst = 0;
        tick();

        // burst 5,6,7,8 held in OUTPUT for 10 cycles, then accepted
        plan = '{5, 6, 7, 8};
        n_clr = 0; n_start = 0;
        pulse_req();
        wait_valid(100, "b5678_valid");
        chk("b5678_clears", n_clr, 4);
        chk("b5678_starts", n_start, 4);
        chk("b5678_data", res_data, 26);
        repeat (10) tick();
        chk("hold_valid_busy", {res_valid, busy}, 2'b11);
        chk("hold_data", res_data, 26);
        res_ready = 1;
        tick();
        chk("accept_release", {res_valid, busy}, 2'b00);

        // reset in the middle of the third wait, then a clean 1,1,1,1 burst
        plan = '{9, 9, -1};
        c0 = n_rise;
        pulse_req();
        wait_rises(c0 + 2, 100, "pre_reset_samples");
        repeat (3) tick();
        chk("mid_wait_busy", busy, 1);
        rst = 1;
        tick();
        chk("rst_all_zero", {busy, cnt_clear, cnt_start, res_valid, res_timeout, res_data}, 0);
        rst = 0;
        tick();
        plan = '{1, 1, 1, 1};
        pulse_req();
        wait_valid(100, "ones_valid");
        chk("ones_no_stale", res_data, 4);
        tick();

        // counter never finishes the second sample
`ifdef TDC_SEQ_TIMEOUT_EN
        plan = '{5, -1, 7, 8};
        pulse_req();
        wait_valid(200, "tmo_valid");
        chk("tmo_data", res_data, 275);
        chk("tmo_flag", res_timeout, 1);
        tick();
`else
        plan = '{5, -1};
        c0 = n_rise;
        pulse_req();
        wait_rises(c0 + 1, 100, "hang_first_sample");
        hb = 0;
        repeat (40) begin tick(); hb += int'(busy); end
        chk("hang_busy_held", hb, 40);
        chk("hang_no_timeout", res_timeout, 0);
        abort = 1;
        tick();
        abort = 0;
        chk("hang_abort_idle", busy, 0);
        tick();
`endif

        // back-to-back bursts with req held, then req pulses while busy
        plan = '{1, 2, 3, 4, 10, 20, 30, 40};
        req = 1;
        wait_valid(100, "b1_valid");
        chk("b1_data", res_data, 10);
        tick();
        chk("gap_idle", {busy, cnt_clear}, 2'b00);
        c0 = n_clr;
        tick();
        chk("gap_clear", cnt_clear, 1);
        repeat (6) begin req = 1'($urandom_range(0, 1)); tick(); end
        req = 0;
        wait_valid(100, "b2_valid");
        chk("b2_data", res_data, 100);
        repeat (10) tick();
        chk("b2_single_burst", n_clr - c0, 4);

        // abort on the same cycle as a done rising edge
        plan = '{3, 4};
        c0 = n_rise;
        pulse_req();
        wait_rises(c0 + 2, 100, "abort_edge_seen");
        abort = 1;
        tick();
        abort = 0;
        chk("abort_priority_idle", busy, 0);
        n_valid = 0;
        repeat (20) tick();
        chk("abort_no_result", n_valid, 0);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            req       = ($urandom_range(0, 3) != 0);
            abort     = ($urandom_range(0, 99) < 3);
            res_ready = ($urandom_range(0, 2) != 0);
            rst       = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 0; abort = 0; req = 0; res_ready = 1;
        repeat (40) tick();
        chk("final_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
